// File: rtl/rv32_core_sequencer.sv
// rv32_core_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM for an RV32I datapath.
// Rev 1.0
`default_nettype none

module rv32_core_sequencer #(
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic        rd_zero,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_sel,
   output logic        mem_we,
   output logic        ir_load,
   output logic        rf_read_en,
   output logic        alu_en,
   output logic        rf_we,
   output logic        pc_en,
   output logic [1:0]  pc_sel,
   output logic [2:0]  state,
   output logic        halted,
   output logic [1:0]  cause,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_SYSTEM  = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

   state_t     cur_state, nxt_state;
   logic [1:0] nxt_cause;
   logic [7:0] wait_cnt;

   logic       req_raw, sel_raw, we_raw, ir_load_raw, rf_read_raw;
   logic       alu_en_raw, rf_we_raw, pc_en_raw;
   logic [1:0] pc_sel_raw;
   logic       op_valid, op_writes_rd, op_is_mem, timeout_hit;

   always_comb begin
      op_valid = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_ALU,
         OP_BRANCH, OP_LOAD, OP_STORE, OP_FENCE, OP_SYSTEM: op_valid = 1'b1;
         default: op_valid = 1'b0;
      endcase
   end

   assign op_writes_rd = (opcode == OP_LUI)  || (opcode == OP_AUIPC) ||
                         (opcode == OP_JAL)  || (opcode == OP_JALR)  ||
                         (opcode == OP_IMM)  || (opcode == OP_ALU)   ||
                         (opcode == OP_LOAD);
   assign op_is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);

   // Fires on the last permitted wait cycle so the FSM leaves after exactly TIMEOUT request cycles.
   assign timeout_hit  = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

   always_comb begin
      nxt_state   = cur_state;
      nxt_cause   = CAUSE_NONE;
      req_raw     = 1'b0;
      sel_raw     = 1'b0;
      we_raw      = 1'b0;
      ir_load_raw = 1'b0;
      rf_read_raw = 1'b0;
      alu_en_raw  = 1'b0;
      rf_we_raw   = 1'b0;
      pc_en_raw   = 1'b0;
      pc_sel_raw  = 2'd0;
      case (cur_state)
         S_FETCH: begin
            if (run) begin
               req_raw = 1'b1;
               if (mem_ready) begin
                  ir_load_raw = 1'b1;
                  nxt_state   = S_DECODE;
               end else if (timeout_hit) begin
                  nxt_state = S_HALT;
                  nxt_cause = CAUSE_TIMEOUT;
               end
            end
         end
         S_DECODE: begin
            rf_read_raw = 1'b1;
            if (op_valid) begin
               nxt_state = S_EXECUTE;
            end else begin
               nxt_state = S_HALT;
               nxt_cause = CAUSE_ILLEGAL;
            end
         end
         S_EXECUTE: begin
            alu_en_raw = 1'b1;
            if (opcode == OP_SYSTEM) begin
               nxt_state = S_HALT;
               nxt_cause = CAUSE_SYSTEM;
            end else if (op_is_mem) begin
               nxt_state = S_MEMORY;
            end else begin
               nxt_state = S_WRITEBACK;
            end
         end
         S_MEMORY: begin
            req_raw = 1'b1;
            sel_raw = 1'b1;
            we_raw  = (opcode == OP_STORE);
            if (mem_ready) begin
               nxt_state = S_WRITEBACK;
            end else if (timeout_hit) begin
               nxt_state = S_HALT;
               nxt_cause = CAUSE_TIMEOUT;
            end
         end
         S_WRITEBACK: begin
            rf_we_raw = op_writes_rd && !rd_zero;
            pc_en_raw = 1'b1;
            if (opcode == OP_JAL)
               pc_sel_raw = 2'd2;
            else if (opcode == OP_JALR)
               pc_sel_raw = 2'd3;
            else if ((opcode == OP_BRANCH) && branch_taken)
               pc_sel_raw = 2'd1;
            nxt_state = S_FETCH;
         end
         S_HALT: begin
            nxt_state = S_HALT;
         end
         default: begin
            nxt_state = S_HALT;
            nxt_cause = CAUSE_ILLEGAL;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cur_state <= S_FETCH;
         halted    <= 1'b0;
         cause     <= CAUSE_NONE;
         instret   <= 32'd0;
         wait_cnt  <= 8'd0;
      end else begin
         cur_state <= nxt_state;
         if ((nxt_state == S_HALT) && (cur_state != S_HALT)) begin
            halted <= 1'b1;
            cause  <= nxt_cause;
         end
         if (cur_state == S_WRITEBACK)
            instret <= instret + 32'd1;
         // Idle cycles and completions both clear, so every request starts counting from zero.
         if (req_raw && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= 8'd0;
      end
   end

   // Gating with RESET drops any outstanding request the moment reset asserts.
   assign mem_req    = RESET & req_raw;
   assign mem_sel    = RESET & sel_raw;
   assign mem_we     = RESET & we_raw;
   assign ir_load    = RESET & ir_load_raw;
   assign rf_read_en = RESET & rf_read_raw;
   assign alu_en     = RESET & alu_en_raw;
   assign rf_we      = RESET & rf_we_raw;
   assign pc_en      = RESET & pc_en_raw;
   assign pc_sel     = RESET ? pc_sel_raw : 2'd0;
   assign state      = cur_state;

endmodule

`default_nettype wire
